pipe_delay_line: RTL and testbench
==================================

Name: pipe_delay_line

Overview:
- Parametrised multi-stage register pipeline for the DSP48A1 datapath. It replaces single register-or-bypass stages on the A/B/C/D/M/P paths.
- Provides DEPTH register stages with valid tracking and a runtime-selectable latency from 0 (combinational bypass) to DEPTH.
- Also provides clock-enable stall, synchronous clear and an occupancy count.
- Latency changes are accepted only when the pipe is drained, so no item is lost or duplicated.

Parameters:
- WIDTH, 18, data width in bits (>=1).
- DEPTH, 4, number of physical stages (>=1).
- LAT_INIT, DEPTH, latency loaded on async reset. Must be <= DEPTH.
- LW, $clog2(DEPTH+1), width of LAT_SEL and OCC. Derived; not overridden.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CEN  in  1  clock enable. 0 stalls all stages.
- SCLR  in  1  synchronous clear. Has priority over CEN.
- LAT_SEL  in  LW  requested latency. Values >DEPTH clamp to DEPTH.
- IN_VALID  in  1  input item valid.
- IN  in  WIDTH  input data.
- OUT_VALID  out  1  output item valid.
- OUT  out  WIDTH  output data.
- OCC  out  LW  number of valid items held in stages.
- LAT_PEND  out  1  clamped LAT_SEL != active latency lat_q.

Behaviour:
- State:
  - data_q[1..DEPTH], vld_q[1..DEPTH].
  - lat_q (LW bits). Holds the clamped value, always 0..DEPTH.
- Async reset (RST_N=0):
  - all data_q=0, vld_q=0, lat_q=LAT_INIT.
  - Outputs while in reset: OUT_VALID=0 and OUT=0 when LAT_INIT>0; OCC=0.
  - Release is synchronous to the next CLK edge.
- SCLR=1 at edge:
  - all data_q=0, vld_q=0; lat_q=clamp(LAT_SEL).
  - Ignores CEN.
- Shift, at an edge with CEN=1 and SCLR=0, for each stage k:
  - Source is IN/IN_VALID for k=1, else stage k-1.
  - k<=lat_q: vld_q[k]<=source valid; data_q[k]<=source data only when source valid=1, else data_q[k] holds.
  - k>lat_q: vld_q[k]<=0, data holds.
  - lat_q==0: every stage loads vld=0 (bypass captures nothing).
- Stall: CEN=0 and SCLR=0 → all data_q and vld_q hold. The lat_q update rule below still applies.
- Output select:
  - lat_q==0: OUT=IN and OUT_VALID=IN_VALID, combinational, zero latency.
  - Otherwise: OUT=data_q[lat_q], OUT_VALID=vld_q[lat_q]. Registered, latency = lat_q accepted cycles (stalled cycles do not count).
- OCC: combinational popcount of vld_q[1..DEPTH].
- LAT_PEND: combinational, clamp(LAT_SEL)!=lat_q.
- Latency update at an edge with SCLR=0:
  - Condition: OCC==0 AND NOT(CEN && IN_VALID && lat_q!=0).
  - Effect: lat_q<=clamp(LAT_SEL).
  - Otherwise lat_q holds and the request stays pending.
  - When an update coincides with a bypass-mode input, that item is output combinationally in the same cycle and is not captured.
- Simultaneous events:
  - SCLR overrides shift and latency rules.
  - RST_N overrides all.

Decomposition:
- Package dsp_pipe_pkg:
  - function clamp_lat(sel, depth).
  - popcount function.
  - RESET_DATA constant (all zeros).
- Sub-module pipe_stage: one WIDTH data register plus valid bit, with RST_N, CEN, SCLR, load_en and force_invalid inputs. Instantiated DEPTH times in a generate loop.
- The top level holds lat_q, the output mux, OCC and LAT_PEND.

Test Plan (WIDTH=18, DEPTH=4 unless stated):
1. Reset/defaults: hold RST_N=0 mid-stream with pipe full → OUT_VALID=0, OCC=0, lat_q=4 immediately. After release, push 0x00011 → OUT=0x00011, OUT_VALID=1 exactly 4 CEN-cycles later.
2. Latency and stall: LAT_SEL=2, push 0x0AAAA, 0x15555 back-to-back, with CEN=0 for 3 cycles after the first edge → items appear in order on OUT. Each appears at the 2nd accepted edge after entry. OCC peaks at 2.
3. Bypass: LAT_SEL=0 on empty pipe, IN=0x3FFFF, IN_VALID=1 → same-cycle OUT=0x3FFFF, OUT_VALID=1. OCC stays 0.
4. Deferred latency change: lat_q=3 with 2 items in flight, LAT_SEL=1 → LAT_PEND=1 until OCC reaches 0. Items emerge at latency 3. LAT_PEND drops the edge after the drain; the next item takes latency 1.
5. SCLR priority: pipe holding 3 items, SCLR=1 and CEN=1 with IN_VALID=1, LAT_SEL=5 → next cycle OCC=0, OUT_VALID=0, lat_q=4 (clamped). The input item is discarded.
6. Edge conflict: lat_q=2, OCC=0, CEN=1, IN_VALID=1, LAT_SEL=0 → lat_q remains 2 for that edge. The item exits at latency 2, then lat_q becomes 0 on the following edge.

Source files
------------

// File: rtl/dsp_pipe_pkg.sv
// Shared types, constants and helpers for the DSP48A1 pipeline delay line.
package dsp_pipe_pkg;

  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned MAX_DEPTH = 64;

  localparam logic [MAX_WIDTH-1:0] RESET_DATA = '0;

  // Requested latency saturated to the number of physical stages.
  function automatic int unsigned clamp_lat(input int unsigned sel, input int unsigned depth);
    return (sel > depth) ? depth : sel;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] bits);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(MAX_DEPTH); i++) begin
      n = n + 32'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One data register plus valid bit of the delay line.
module pipe_stage
  import dsp_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 18
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CEN,
  input  logic             SCLR,
  input  logic             load_en,
  input  logic             force_invalid,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             vld_q,
  output logic [WIDTH-1:0] data_q
);

  logic             vld_d;
  logic [WIDTH-1:0] data_d;

  // Data only moves with a valid item so idle cycles do not toggle the register.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (SCLR) begin
      vld_d  = 1'b0;
      data_d = WIDTH'(RESET_DATA);
    end else if (CEN) begin
      if (force_invalid) begin
        vld_d = 1'b0;
      end else if (load_en) begin
        vld_d = src_valid;
        if (src_valid) begin
          data_d = src_data;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q  <= 1'b0;
      data_q <= WIDTH'(RESET_DATA);
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/pipe_delay_line.sv
// Multi-stage register pipeline with runtime latency 0..DEPTH, stall, clear and occupancy.
module pipe_delay_line
  import dsp_pipe_pkg::*;
#(
  parameter int unsigned WIDTH    = 18,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LAT_INIT = DEPTH,
  parameter int unsigned LW       = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CEN,
  input  logic             SCLR,
  input  logic [LW-1:0]    LAT_SEL,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] IN,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] OUT,
  output logic [LW-1:0]    OCC,
  output logic             LAT_PEND
);

  logic [LW-1:0]    lat_q;
  logic [LW-1:0]    lat_d;
  logic [LW-1:0]    lat_sel_clamped;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_vld;

  assign lat_sel_clamped = LW'(clamp_lat(32'(LAT_SEL), DEPTH));

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
    logic [WIDTH-1:0] src_data;
    logic             src_valid;
    logic             in_range;

    if (k == 0) begin : g_first
      assign src_data  = IN;
      assign src_valid = IN_VALID;
    end else begin : g_chain
      assign src_data  = stage_data[k-1];
      assign src_valid = stage_vld[k-1];
    end

    // Stages beyond the active latency drain to invalid; latency 0 captures nothing.
    assign in_range = (32'(lat_q) >= 32'(k + 1));

    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .CEN          (CEN),
      .SCLR         (SCLR),
      .load_en      (in_range),
      .force_invalid(!in_range || (lat_q == '0)),
      .src_valid    (src_valid),
      .src_data     (src_data),
      .vld_q        (stage_vld[k]),
      .data_q       (stage_data[k])
    );
  end

  // Output tap: combinational bypass at latency 0, otherwise stage lat_q.
  always_comb begin
    OUT       = IN;
    OUT_VALID = IN_VALID;
    if (lat_q != '0) begin
      OUT       = WIDTH'(RESET_DATA);
      OUT_VALID = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (lat_q == LW'(i + 1)) begin
          OUT       = stage_data[i];
          OUT_VALID = stage_vld[i];
        end
      end
    end
  end

  assign OCC      = LW'(popcount(MAX_DEPTH'(stage_vld)));
  assign LAT_PEND = (lat_sel_clamped != lat_q);

  // Latency switches only on an empty pipe with no item about to enter it.
  always_comb begin
    lat_d = lat_q;
    if (SCLR) begin
      lat_d = lat_sel_clamped;
    end else if ((OCC == '0) && !(CEN && IN_VALID && (lat_q != '0))) begin
      lat_d = lat_sel_clamped;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lat_q <= LW'(LAT_INIT);
    end else begin
      lat_q <= lat_d;
    end
  end

endmodule

// File: tb/tb_pipe_delay_line.sv
// Self-checking bench for pipe_delay_line: directed sequences, vector table, random vs model.
module tb_pipe_delay_line;

  localparam int unsigned WIDTH = 18;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;

  logic             clk;
  logic             rst_n;
  logic             cen;
  logic             sclr;
  logic [LW-1:0]    lat_sel;
  logic             in_valid;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic [WIDTH-1:0] dout;
  logic [LW-1:0]    occ;
  logic             lat_pend;

  int checks;
  int failures;

  pipe_delay_line #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CEN      (cen),
    .SCLR     (sclr),
    .LAT_SEL  (lat_sel),
    .IN_VALID (in_valid),
    .IN       (din),
    .OUT_VALID(out_valid),
    .OUT      (dout),
    .OCC      (occ),
    .LAT_PEND (lat_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             cen;
    logic             iv;
    logic [WIDTH-1:0] din;
    logic [LW-1:0]    sel;
    logic             ev;
    logic [WIDTH-1:0] eo;
    logic [LW-1:0]    eocc;
    logic             epend;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               age;
  } item_t;

  vec_t  tbl [25];
  item_t mq[$];
  item_t nq[$];
  int    m_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mclamp(input int s);
    return (s > int'(DEPTH)) ? int'(DEPTH) : s;
  endfunction

  task automatic drive(input logic c, input logic s, input logic v, input logic [WIDTH-1:0] d,
                       input logic [LW-1:0] l);
    cen = c; sclr = s; in_valid = v; din = d; lat_sel = l;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic             exp_v;
    logic [WIDTH-1:0] exp_d;
    logic             upd;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(0, 0, 0, '0, 3'd4);

    // Reset defaults
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(dout), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_edge();

    // Fill the pipe, then reset mid-stream
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 1, WIDTH'(i), 3'd4);
      next_edge();
    end
    drive(1, 0, 0, '0, 3'd3);
    chk("full_occ", 32'(occ), 32'd4);
    chk("full_out", 32'(dout), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_occ", 32'(occ), 32'd0);
    chk("midrst_lat_pend", 32'(lat_pend), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 1, 18'h00011, 3'd4);
    next_edge();
    drive(1, 0, 0, '0, 3'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lat4_not_yet", 32'(out_valid), 32'd0);
      if (i == 1) begin
        cen = 1'b0;
        next_edge();
        @(negedge clk);
        chk("lat4_stalled", 32'(out_valid), 32'd0);
        cen = 1'b1;
      end
      next_edge();
    end
    @(negedge clk);
    chk("lat4_out_valid", 32'(out_valid), 32'd1);
    chk("lat4_out", 32'(dout), 32'h00011);
    next_edge();

    // SCLR priority over shift and latency hold
    drive(1, 0, 1, 18'h00021, 3'd4); next_edge();
    drive(1, 0, 1, 18'h00022, 3'd4); next_edge();
    drive(1, 0, 1, 18'h00023, 3'd4); next_edge();
    drive(1, 1, 1, 18'h3FFFF, 3'd5);
    @(negedge clk);
    chk("pre_sclr_occ", 32'(occ), 32'd3);
    next_edge();
    drive(0, 0, 0, '0, 3'd5);
    @(negedge clk);
    chk("sclr_occ", 32'(occ), 32'd0);
    chk("sclr_out_valid", 32'(out_valid), 32'd0);
    chk("sclr_lat_clamped", 32'(lat_pend), 32'd0);
    cen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_edge();
      @(negedge clk);
      chk("sclr_discarded", 32'(out_valid), 32'd0);
    end
    lat_sel = 3'd4;
    next_edge();

    // Vector table: latency 2 with stall, bypass, deferred change, edge conflict
    tbl[0]  = '{1'b1, 1'b0, 18'h00000, 3'd2, 1'b0, 18'h00000, 3'd0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 18'h0AAAA, 3'd2, 1'b0, 18'h00000, 3'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 18'h15555, 3'd2, 1'b0, 18'h00000, 3'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 18'h15555, 3'd2, 1'b0, 18'h00000, 3'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 18'h15555, 3'd2, 1'b0, 18'h00000, 3'd1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 18'h15555, 3'd2, 1'b0, 18'h00000, 3'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 18'h00000, 3'd2, 1'b1, 18'h0AAAA, 3'd2, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 18'h00000, 3'd2, 1'b1, 18'h15555, 3'd1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 18'h00000, 3'd0, 1'b0, 18'h00000, 3'd0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 18'h3FFFF, 3'd0, 1'b1, 18'h3FFFF, 3'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 18'h00000, 3'd3, 1'b0, 18'h00000, 3'd0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 18'h00101, 3'd3, 1'b0, 18'h00000, 3'd0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 18'h00202, 3'd1, 1'b0, 18'h00000, 3'd1, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 18'h00000, 3'd1, 1'b0, 18'h00000, 3'd2, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 18'h00000, 3'd1, 1'b1, 18'h00101, 3'd2, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 18'h00000, 3'd1, 1'b1, 18'h00202, 3'd1, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 18'h00000, 3'd1, 1'b0, 18'h00000, 3'd0, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 18'h00303, 3'd1, 1'b0, 18'h00000, 3'd0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 18'h00000, 3'd1, 1'b1, 18'h00303, 3'd1, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 18'h00000, 3'd2, 1'b0, 18'h00000, 3'd0, 1'b1};
    tbl[20] = '{1'b1, 1'b1, 18'h12345, 3'd0, 1'b0, 18'h00000, 3'd0, 1'b1};
    tbl[21] = '{1'b1, 1'b0, 18'h00000, 3'd0, 1'b0, 18'h00000, 3'd1, 1'b1};
    tbl[22] = '{1'b1, 1'b0, 18'h00000, 3'd0, 1'b1, 18'h12345, 3'd1, 1'b1};
    tbl[23] = '{1'b1, 1'b0, 18'h00000, 3'd0, 1'b0, 18'h00000, 3'd0, 1'b1};
    tbl[24] = '{1'b1, 1'b1, 18'h2468A, 3'd0, 1'b1, 18'h2468A, 3'd0, 1'b0};
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].cen, 1'b0, tbl[i].iv, tbl[i].din, tbl[i].sel);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("vec%0d_out", i), 32'(dout), 32'(tbl[i].eo));
      chk($sformatf("vec%0d_occ", i), 32'(occ), 32'(tbl[i].eocc));
      chk($sformatf("vec%0d_lat_pend", i), 32'(lat_pend), 32'(tbl[i].epend));
      next_edge();
    end

    // Random stimulus against a queue-of-ages reference model
    drive(0, 1, 0, '0, 3'd3);
    next_edge();
    mq.delete();
    m_lat = 3;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cen      = ($urandom % 4) != 0;
      in_valid = ($urandom % 3) != 0;
      din      = WIDTH'($urandom);
      sclr     = ($urandom % 60) == 0;
      if (($urandom % 12) == 0) lat_sel = LW'($urandom % 8);
      @(negedge clk);
      exp_v = 1'b0;
      exp_d = '0;
      if (m_lat == 0) begin
        exp_v = in_valid;
        exp_d = din;
      end else begin
        foreach (mq[j]) if (mq[j].age == m_lat) begin
          exp_v = 1'b1;
          exp_d = mq[j].d;
        end
      end
      chk("rnd_out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) chk("rnd_out", 32'(dout), 32'(exp_d));
      chk("rnd_occ", 32'(occ), 32'(mq.size()));
      chk("rnd_lat_pend", 32'(lat_pend), 32'(mclamp(int'(lat_sel)) != m_lat));
      if (sclr) begin
        mq.delete();
        m_lat = mclamp(int'(lat_sel));
      end else begin
        upd = (mq.size() == 0) && !(cen && in_valid && m_lat != 0);
        if (cen) begin
          nq.delete();
          foreach (mq[j]) if (mq[j].age + 1 <= m_lat) nq.push_back('{mq[j].d, mq[j].age + 1});
          if (in_valid && m_lat > 0) nq.push_back('{din, 1});
          mq = nq;
        end
        if (upd) m_lat = mclamp(int'(lat_sel));
      end
      next_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
